// File: rtl/mem_unified_ws.sv
// rtl/mem_unified_ws.sv - unified instruction/data memory with wait states, byte lanes and load extension
// Optional macro MEM_MISALIGN_CHK_EN: flags misaligned half/word accesses and suppresses their effects.
module mem_unified_ws #(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Req,
  input  logic        WE,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Busy,
  output logic        Misalign
);
  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [2:0]  lat_f;
  logic [31:0] lat_adr, lat_wd;
  logic [31:0] mem [DEPTH_WORDS];

  logic        acc_we;
  logic [2:0]  acc_f;
  logic [31:0] acc_adr, acc_wd;
  logic [AW-1:0] idx;
  logic [31:0] rd_word, ld_val, wr_val;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [3:0]  be;
  logic        commit;
  logic        unused_adr_hi;

  // With zero wait states the commit edge is the accept edge, so use the live inputs in IDLE.
  assign acc_we  = (state == S_IDLE) ? WE        : lat_we;
  assign acc_f   = (state == S_IDLE) ? Funct3    : lat_f;
  assign acc_adr = (state == S_IDLE) ? Adr       : lat_adr;
  assign acc_wd  = (state == S_IDLE) ? WriteData : lat_wd;

  assign idx           = acc_adr[AW+1:2];
  assign rd_word       = mem[idx];
  assign unused_adr_hi = ^acc_adr[31:AW+2];
  assign byte_v        = rd_word[{acc_adr[1:0], 3'b000} +: 8];
  assign half_v        = acc_adr[1] ? rd_word[31:16] : rd_word[15:0];

  assign commit = ((state == S_IDLE) && Req && (WAIT_CYCLES == 0)) ||
                  ((state == S_WAIT) && (cnt == 4'd0));

`ifdef MEM_MISALIGN_CHK_EN
  logic mis, mis_q;
`endif

  always_comb begin
    ld_val = rd_word;
    wr_val = acc_wd;
    be     = 4'b0000;
    case (acc_f)
      3'b000: begin
        ld_val = {{24{byte_v[7]}}, byte_v};
        wr_val = {4{acc_wd[7:0]}};
        be     = 4'b0001 << acc_adr[1:0];
      end
      3'b001: begin
        ld_val = {{16{half_v[15]}}, half_v};
        wr_val = {2{acc_wd[15:0]}};
        be     = acc_adr[1] ? 4'b1100 : 4'b0011;
      end
      3'b010:  be = 4'b1111;
      3'b100:  ld_val = {24'd0, byte_v};
      3'b101:  ld_val = {16'd0, half_v};
      default: ;
    endcase
`ifdef MEM_MISALIGN_CHK_EN
    mis = (((acc_f == 3'b001) || (acc_f == 3'b101)) && acc_adr[0]) ||
          ((acc_f == 3'b010) && (acc_adr[1:0] != 2'b00));
    if (mis) begin
      ld_val = 32'd0;
      be     = 4'b0000;
    end
`endif
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (Req) state_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      S_WAIT:  if (cnt == 4'd0) state_next = S_RESP;
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      lat_we   <= 1'b0;
      lat_f    <= 3'd0;
      lat_adr  <= 32'd0;
      lat_wd   <= 32'd0;
      ReadData <= 32'd0;
`ifdef MEM_MISALIGN_CHK_EN
      mis_q    <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if ((state == S_IDLE) && Req) begin
        lat_we  <= WE;
        lat_f   <= Funct3;
        lat_adr <= Adr;
        lat_wd  <= WriteData;
        cnt     <= CNT_INIT;
      end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (commit && !acc_we) ReadData <= ld_val;
`ifdef MEM_MISALIGN_CHK_EN
      if (commit) mis_q <= mis;
`endif
    end
  end

  // Storage is not reset; a store caught by reset before its commit edge never lands.
  always_ff @(posedge clk) begin
    if (!rst && commit && acc_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wr_val[8*i +: 8];
      end
    end
  end

  assign Ready = (state == S_RESP);
  assign Busy  = (state != S_IDLE);
`ifdef MEM_MISALIGN_CHK_EN
  assign Misalign = Ready & mis_q;
`else
  assign Misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_unified_ws.sv
// tb/tb_mem_unified_ws.sv - randomized bench for mem_unified_ws against a transaction-level memory model
module tb_mem_unified_ws;
  localparam int DEPTH = 64;
  localparam int WC    = 2;
`ifdef MEM_MISALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [2:0]  f = 3'd0;
  logic [31:0] adr = 32'd0, wd = 32'd0;
  logic [31:0] rd;
  logic        ready, busy, mis;

  logic        z_req = 1'b0, z_we = 1'b0;
  logic [2:0]  z_f = 3'd0;
  logic [31:0] z_adr = 32'd0, z_wd = 32'd0;
  logic [31:0] z_rd;
  logic        z_ready, z_busy, z_mis;

  int n_cmp = 0, n_bad = 0;
  bit checking = 1'b0;

  mem_unified_ws #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst), .Req(req), .WE(we), .Funct3(f), .Adr(adr), .WriteData(wd),
    .ReadData(rd), .Ready(ready), .Busy(busy), .Misalign(mis));

  mem_unified_ws #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .INIT_FILE("")) dut_z (
    .clk(clk), .rst(rst), .Req(z_req), .WE(z_we), .Funct3(z_f), .Adr(z_adr), .WriteData(z_wd),
    .ReadData(z_rd), .Ready(z_ready), .Busy(z_busy), .Misalign(z_mis));

  always #5 clk = ~clk;

  // Transaction-level model: remaining busy cycles, shadow memory, expected read result.
  bit [31:0] shadow [DEPTH];
  int        rem = 0;
  bit        t_we, t_mis = 1'b0;
  bit [2:0]  t_f;
  bit [31:0] t_adr, t_wd, exp_rd = 32'd0;

  function automatic void apply();
    int        idx = int'((t_adr >> 2) % DEPTH);
    bit [31:0] w   = shadow[idx];
    bit [31:0] v;
    int        sh;
    bit        half = (t_f == 3'd1) || (t_f == 3'd5);
    bit        word = (t_f == 3'd2);
    t_mis = CHK && ((half && t_adr[0]) || (word && (t_adr[1:0] != 2'b00)));
    if (!t_we) begin
      if (t_mis) exp_rd = 32'd0;
      else case (t_f)
        3'd0, 3'd4: begin
          v = (w >> (8 * t_adr[1:0])) & 32'hFF;
          exp_rd = (t_f == 3'd0 && v >= 128) ? v - 32'd256 : v;
        end
        3'd1, 3'd5: begin
          v = (w >> (16 * t_adr[1])) & 32'hFFFF;
          exp_rd = (t_f == 3'd1 && v >= 32768) ? v - 32'd65536 : v;
        end
        default: exp_rd = w;
      endcase
    end else if (!t_mis) begin
      case (t_f)
        3'd0: begin sh = 8 * t_adr[1:0];  shadow[idx] = (w & ~(32'hFF << sh))   | ((t_wd & 32'hFF) << sh); end
        3'd1: begin sh = 16 * t_adr[1];   shadow[idx] = (w & ~(32'hFFFF << sh)) | ((t_wd & 32'hFFFF) << sh); end
        3'd2: shadow[idx] = t_wd;
        default: ;
      endcase
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      rem = 0; exp_rd = 32'd0; t_mis = 1'b0;
    end else begin
      if (rem > 0) rem--;
      else if (req) begin
        t_we = we; t_f = f; t_adr = adr; t_wd = wd; rem = WC + 1;
      end
      if (rem == 1) apply();
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("ready", {31'd0, ready}, {31'd0, rem == 1});
      chk("busy", {31'd0, busy}, {31'd0, rem > 0});
      chk("misalign", {31'd0, mis}, {31'd0, (rem == 1) && t_mis});
      chk("read_data", rd, exp_rd);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_op(input bit w, input logic [2:0] fn, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] r, output logic m);
    int k;
    req = 1'b1; we = w; f = fn; adr = a; wd = d;
    r = 32'd0; m = 1'b0;
    for (k = 1; k <= 20; k++) begin
      step();
      if (ready === 1'b1) break;
      req = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
      f = 3'($urandom); adr = $urandom; wd = $urandom;
    end
    chk("latency", k, WC + 1);
    r = rd; m = mis;
    req = 1'b0;
    step();
  endtask

  task automatic st(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r; logic m;
    do_op(1'b1, fn, a, d, r, m);
  endtask

  task automatic ld(input string name, input logic [2:0] fn, input logic [31:0] a,
                    input logic [31:0] exp, input logic exp_m);
    logic [31:0] r; logic m;
    do_op(1'b0, fn, a, 32'd0, r, m);
    chk(name, r, exp);
    chk({name, "_model"}, exp_rd, exp);
    chk({name, "_mis"}, {31'd0, m}, {31'd0, exp_m});
  endtask

  task automatic z_chk_step(input string name, input logic exp_ready);
    step();
    chk(name, {31'd0, z_ready}, {31'd0, exp_ready});
    chk({name, "_busy"}, {31'd0, z_busy}, {31'd0, exp_ready});
  endtask

  initial begin
    #1 rst = 1'b1;
    step(); step();
    chk("rst_read_data", rd, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_misalign", {31'd0, mis}, 32'd0);
    rst = 1'b0;
    checking = 1'b1;
    step();

    for (int i = 0; i < DEPTH; i++) st(3'd2, 32'(4 * i), $urandom);

    st(3'd2, 32'h10, 32'hDEADBEEF);
    ld("t1_lw", 3'd2, 32'h10, 32'hDEADBEEF, 1'b0);

    st(3'd2, 32'h10, 32'h11223344);
    st(3'd0, 32'h13, 32'h00000080);
    ld("t2_lw", 3'd2, 32'h10, 32'h80223344, 1'b0);
    ld("t2_lb", 3'd0, 32'h13, 32'hFFFFFF80, 1'b0);
    ld("t2_lbu", 3'd4, 32'h13, 32'h00000080, 1'b0);

    st(3'd2, 32'h20, 32'hAAAA5555);
    st(3'd1, 32'h22, 32'h00008001);
    ld("t3_lh", 3'd1, 32'h22, 32'hFFFF8001, 1'b0);
    ld("t3_lhu", 3'd5, 32'h22, 32'h00008001, 1'b0);
    ld("t3_lw", 3'd2, 32'h20, 32'h80015555, 1'b0);

    ld("t6_lw_mis", 3'd2, 32'h21, CHK ? 32'd0 : 32'h80015555, CHK);
    st(3'd2, 32'h22, 32'h12345678);
    ld("t6_after_sw", 3'd2, 32'h20, CHK ? 32'h80015555 : 32'h12345678, 1'b0);

    req = 1'b1; we = 1'b1; f = 3'd2; adr = 32'h10; wd = 32'h0BADF00D;
    step();
    req = 1'b0; rst = 1'b1;
    step();
    chk("t5_rst_rd", rd, 32'd0);
    chk("t5_rst_ready", {31'd0, ready}, 32'd0);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    step(); step(); step();
    ld("t5_old", 3'd2, 32'h10, 32'h80223344, 1'b0);

    st(3'd2, 32'h10 + 32'(4 * DEPTH), 32'hCAFEF00D);
    ld("wrap", 3'd2, 32'h10, 32'hCAFEF00D, 1'b0);

    // Zero-wait instance: Req held high, accepted every other edge; busy-cycle fields ignored.
    z_req = 1'b1; z_we = 1'b1; z_f = 3'd2; z_adr = 32'h44; z_wd = 32'd0;
    z_chk_step("z_first", 1'b1);
    for (int i = 0; i < 8; i++) begin
      z_adr = (i % 2 == 0) ? 32'h44 : 32'h40;
      z_wd  = (i % 2 == 0) ? 32'h0BAD0000 + 32'(i) : 32'h1000 + 32'(i);
      z_chk_step("z_held", (i % 2) == 1);
    end
    z_req = 1'b0;
    step();
    z_req = 1'b1; z_we = 1'b0; z_adr = 32'h44;
    step();
    chk("z_ld44", z_rd, 32'd0);
    z_req = 1'b0;
    step();
    z_req = 1'b1; z_adr = 32'h40;
    step();
    chk("z_ld40", z_rd, 32'h1007);
    z_req = 1'b0;
    step();

    for (int c = 0; c < 600; c++) begin
      step();
      rst = ($urandom_range(0, 79) == 0);
      req = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
      f = 3'($urandom); adr = $urandom; wd = $urandom;
    end
    rst = 1'b0; req = 1'b0;
    repeat (6) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
